// File: rtl/gth_rx_frame_aligner.sv
// gth_rx_frame_aligner
// Finds a periodic sync word at any bit offset in the raw GTH word stream,
// qualifies and tracks frame lock, and emits bit-aligned payload words with
// start-of-frame marking. Lives entirely in the RX word-clock domain.
module gth_rx_frame_aligner #(
    parameter int unsigned                 DATA_WIDTH   = 32,
    parameter logic [DATA_WIDTH-1:0]       SYNC_PATTERN = 32'hBC5A_3CC5,
    parameter int unsigned                 FRAME_LEN    = 16,
    parameter int unsigned                 LOCK_COUNT   = 4,
    parameter int unsigned                 UNLOCK_COUNT = 3
) (
    input  logic                  RX_WORDCLK_i,
    input  logic                  RX_RESETN_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  data_valid_i,
    input  logic                  realign_i,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  data_valid_o,
    output logic                  sof_o,
    output logic                  locked_o,
    output logic [4:0]            bit_offset_o,
    output logic [15:0]           lock_loss_count_o
);

    localparam int unsigned FCNT_W = $clog2(FRAME_LEN);
    localparam logic [FCNT_W-1:0] FCNT_LAST = FCNT_W'(FRAME_LEN - 1);

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } state_t;

    state_t            state, state_nxt;
    logic [31:0]       prev_word;
    logic [62:0]       cat;          // bit 63 of {data_i, prev_word} is never inside a window
    logic [31:0]       sel_win;
    logic              sel_match;
    logic              hit;
    logic [4:0]        hit_k;
    logic [FCNT_W-1:0] fcnt, fcnt_nxt, fcnt_inc;
    logic [3:0]        good, good_nxt;
    logic [3:0]        miss, miss_nxt;
    logic [4:0]        offset_nxt;
    logic [15:0]       loss_nxt, loss_sat;
    logic              pay_valid_nxt, sof_nxt;

    assign cat       = {data_i[30:0], prev_word};
    assign sel_win   = cat[bit_offset_o +: 32];
    assign sel_match = (sel_win == SYNC_PATTERN);
    assign fcnt_inc  = (fcnt == FCNT_LAST) ? '0 : fcnt + 1'b1;
    assign loss_sat  = (lock_loss_count_o == 16'hFFFF) ? 16'hFFFF : lock_loss_count_o + 16'd1;

    // Parallel sync search over all 32 offsets; the descending scan leaves the lowest hit.
    always_comb begin
        hit   = 1'b0;
        hit_k = '0;
        for (int k = 31; k >= 0; k--) begin
            if (cat[k +: 32] == SYNC_PATTERN) begin
                hit   = 1'b1;
                hit_k = 5'(k);
            end
        end
    end

    // Next-state, counter and payload-flag decode.
    always_comb begin
        // NOTE: every signal gets a default here so no path leaves it unassigned (no latches).
        state_nxt     = state;
        fcnt_nxt      = data_valid_i ? fcnt_inc : fcnt;
        good_nxt      = good;
        miss_nxt      = miss;
        offset_nxt    = bit_offset_o;
        loss_nxt      = lock_loss_count_o;
        pay_valid_nxt = data_valid_i && !realign_i && (state == LOCKED) && (fcnt != '0);
        sof_nxt       = pay_valid_nxt && (fcnt == FCNT_W'(1));

        if (realign_i) begin
            // Realign overrides any lock/unlock decision taken in the same cycle.
            state_nxt = SEARCH;
            good_nxt  = '0;
            miss_nxt  = '0;
            if (state == LOCKED) loss_nxt = loss_sat;
        end else if (data_valid_i) begin
            case (state)
                SEARCH: begin
                    if (hit) begin
                        // The hit word itself is slot 0, so the next word is slot 1.
                        offset_nxt = hit_k;
                        fcnt_nxt   = FCNT_W'(1);
                        good_nxt   = 4'd1;
                        miss_nxt   = '0;
                        state_nxt  = (LOCK_COUNT == 1) ? LOCKED : VERIFY;
                    end
                end
                VERIFY: begin
                    if (fcnt == '0) begin
                        if (sel_match) begin
                            good_nxt = good + 4'd1;
                            if (good_nxt == 4'(LOCK_COUNT)) state_nxt = LOCKED;
                        end else begin
                            good_nxt  = '0;
                            state_nxt = SEARCH;
                        end
                    end
                end
                LOCKED: begin
                    if (fcnt == '0) begin
                        if (sel_match) begin
                            miss_nxt = '0;
                        end else begin
                            miss_nxt = miss + 4'd1;
                            if (miss_nxt == 4'(UNLOCK_COUNT)) begin
                                state_nxt = SEARCH;
                                miss_nxt  = '0;
                                good_nxt  = '0;
                                loss_nxt  = loss_sat;
                            end
                        end
                    end
                end
                default: state_nxt = SEARCH;
            endcase
        end
    end

    // Control state register; everything here is cleared by the async reset.
    always_ff @(posedge RX_WORDCLK_i or negedge RX_RESETN_i) begin
        if (!RX_RESETN_i) begin
            state             <= SEARCH;
            fcnt              <= '0;
            good              <= '0;
            miss              <= '0;
            bit_offset_o      <= '0;
            lock_loss_count_o <= '0;
            locked_o          <= 1'b0;
            data_valid_o      <= 1'b0;
            sof_o             <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state             <= state_nxt;
            fcnt              <= fcnt_nxt;
            good              <= good_nxt;
            miss              <= miss_nxt;
            bit_offset_o      <= offset_nxt;
            lock_loss_count_o <= loss_nxt;
            locked_o          <= (state_nxt == LOCKED);
            data_valid_o      <= pay_valid_nxt;
            sof_o             <= sof_nxt;
        end
    end

    // Word window history and aligned output word; both hold during stalls.
    always_ff @(posedge RX_WORDCLK_i or negedge RX_RESETN_i) begin
        if (!RX_RESETN_i) begin
            prev_word <= '0;
            data_o    <= '0;
        end else if (data_valid_i) begin
            prev_word <= data_i;
            data_o    <= sel_win;
        end
    end

endmodule
